uart_axis: RTL and testbench
============================

Name: uart_axis

Overview:
- AXI4-Stream to UART bridge for a byte-oriented serial link, format 8N1 (8 data bits, no parity, 1 stop bit).
- Slave stream side: accepts bytes and serialises them onto `tx`.
- Master stream side: deserialises bytes arriving on `rx` and presents them as stream beats.
- Sits between host-side stream logic and the board UART pins. Supports external loopback (`tx` wired to `rx`).

Parameters:
- DATA_WIDTH, 8, stream data width and UART data bits per frame. Only the value 8 is required to work.
- CLKS_PER_BIT, 868, `aclk` cycles per UART bit (100 MHz / 115200 baud). Minimum legal value is 4.

Ports:
- aclk  input  1  system clock; all logic on the rising edge.
- arstn  input  1  reset, asynchronous, active-low.
- s_data_tdata  input  DATA_WIDTH  byte to transmit.
- s_data_tvalid  input  1  transmit byte valid.
- s_data_tready  output  1  transmitter can accept a byte.
- m_data_tdata  output  DATA_WIDTH  received byte.
- m_data_tvalid  output  1  received byte valid.
- m_data_tready  input  1  downstream accepts the received byte.
- tx  output  1  UART serial out; idles high.
- rx  input  1  UART serial in; asynchronous to `aclk`.
- Positional declaration order is fixed, because instances connect by position: s_data_tdata, s_data_tvalid, s_data_tready, m_data_tdata, m_data_tvalid, m_data_tready, tx, rx, aclk, arstn.

Behaviour:
- Reset (`arstn` low, asynchronous) values:
  - tx=1, s_data_tready=0, m_data_tvalid=0, m_data_tdata=0.
  - Both FSMs go to IDLE and all counters clear.
  - The first rising edge after release sets s_data_tready=1.
- Reset mid-frame aborts the frame immediately: tx returns to 1 and any partial RX byte is discarded.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: s_data_tready=1 (registered), tx=1.
  - Handshake on any edge where s_data_tvalid and s_data_tready are both 1: latch s_data_tdata, go to START, s_data_tready=0 on the next cycle.
  - START: tx=0 for CLKS_PER_BIT cycles; tx falls on the first cycle after the handshake.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE with s_data_tready=1 again.
  - Frame length is exactly 10*CLKS_PER_BIT cycles. Minimum spacing between consecutive handshakes is 10*CLKS_PER_BIT+1 cycles.
  - A held s_data_tvalid with changing s_data_tdata is legal; only the value present at the handshake edge is sent.
- RX input conditioning: `rx` passes through a 2-flop synchroniser, reset to 1.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: a falling edge on synchronised rx starts a frame.
  - START: wait CLKS_PER_BIT/2 cycles, then sample. If the sample is high, treat it as a glitch and return to IDLE. Otherwise proceed.
  - DATA: sample every CLKS_PER_BIT cycles at bit centre, LSB first into a shift register.
  - STOP: sample at bit centre.
    - If 1: load m_data_tdata with the byte and set m_data_tvalid=1 on the next edge.
    - If 0 (framing error): discard the byte, no output. Wait for rx high before returning to IDLE.
  - After a good stop sample, return to IDLE immediately. The remaining half stop bit is not waited out.
- Output register:
  - m_data_tvalid stays high until an edge with m_data_tready=1; it clears on that edge.
  - m_data_tdata is held stable while valid.
- Overrun: if a new byte completes while m_data_tvalid=1 and no handshake occurs on that edge, the new byte overwrites m_data_tdata and m_data_tvalid stays 1.
- Simultaneous handshake and new byte on the same edge: the new byte is loaded and m_data_tvalid stays 1.
- TX and RX are fully independent; full-duplex operation is required.

Test Plan:
- Reset hold 50 ns, then release → tx=1 throughout reset, m_data_tvalid=0, s_data_tready=1 one edge after release.
- CLKS_PER_BIT=4, send 0x11 → tx pattern 0,1,0,0,0,1,0,0,0,1 (4 cycles each); s_data_tready low for exactly 40 cycles.
- Loopback (tx→rx), s_data_tvalid held high, m_data_tready=1, data incremented on each s_data_tready falling edge → m_data_tvalid pulses one cycle per frame with 0x11, 0x12, 0x13… in order, no gaps or duplicates.
- rx driven with 0xA5 frame, m_data_tready=0 → m_data_tvalid=1 with 0xA5 held. Then send 0x3C → tdata becomes 0x3C, valid stays 1. Assert tready → valid clears next edge.
- rx low pulse of CLKS_PER_BIT/2−1 cycles → no output. Full frame with stop bit 0 → no m_data_tvalid, and the next valid frame is received correctly.
- arstn asserted mid-TX-frame → tx=1 immediately (asynchronous); after release, the next byte is transmitted with a correct full frame.

Source files
------------

// File: rtl/uart_axis.sv
// AXI4-Stream <-> UART (8N1) bridge: slave stream bytes go out on tx, bytes
// deserialised from rx are offered on the master stream with overwrite-on-overrun.
//
// tx fsm state | meaning
// TX_IDLE      | line high, s_data_tready=1, waiting for a stream beat
// TX_START     | driving the start bit (low)
// TX_DATA      | shifting data bits out LSB first
// TX_STOP      | driving the stop bit (high)
//
// rx fsm state | meaning
// RX_IDLE      | waiting for a falling edge on synchronised rx
// RX_START     | half-bit wait, then start bit re-checked (glitch filter)
// RX_DATA      | sampling data bits at bit centre, LSB first
// RX_STOP      | sampling stop bit; on framing error wait for line high
module uart_axis #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic [DATA_WIDTH-1:0] s_data_tdata,
  input  logic                  s_data_tvalid,
  output logic                  s_data_tready,
  output logic [DATA_WIDTH-1:0] m_data_tdata,
  output logic                  m_data_tvalid,
  input  logic                  m_data_tready,
  output logic                  tx,
  input  logic                  rx,
  input  logic                  aclk,
  input  logic                  arstn
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // ---------------------------------------------------------------- transmit
  tx_state_t             tx_state, tx_state_nxt;
  logic [CNT_W-1:0]      tx_cnt, tx_cnt_nxt;
  logic [BIT_W-1:0]      tx_bit, tx_bit_nxt;
  logic [DATA_WIDTH-1:0] tx_shift, tx_shift_nxt;
  logic                  tx_nxt;
  logic                  tready_nxt;

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      tx_state      <= TX_IDLE;
      tx_cnt        <= '0;
      tx_bit        <= '0;
      tx_shift      <= '0;
      tx            <= 1'b1;
      s_data_tready <= 1'b0;
    end else begin
      tx_state      <= tx_state_nxt;
      tx_cnt        <= tx_cnt_nxt;
      tx_bit        <= tx_bit_nxt;
      tx_shift      <= tx_shift_nxt;
      tx            <= tx_nxt;
      s_data_tready <= tready_nxt;
    end
  end

  // tx and tready are registered, so every bit is decided one edge ahead
  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt;
    tx_bit_nxt   = tx_bit;
    tx_shift_nxt = tx_shift;
    tx_nxt       = tx;
    tready_nxt   = s_data_tready;
    unique case (tx_state)
      TX_IDLE: begin
        tx_nxt     = 1'b1;
        tready_nxt = 1'b1;
        if (s_data_tvalid && s_data_tready) begin
          tx_shift_nxt = s_data_tdata;
          tx_cnt_nxt   = CNT_BIT;
          tx_nxt       = 1'b0;
          tready_nxt   = 1'b0;
          tx_state_nxt = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt == '0) begin
          tx_cnt_nxt   = CNT_BIT;
          tx_bit_nxt   = '0;
          tx_nxt       = tx_shift[0];
          tx_shift_nxt = tx_shift >> 1;
          tx_state_nxt = TX_DATA;
        end else begin
          tx_cnt_nxt = tx_cnt - CNT_ONE;
        end
      end
      TX_DATA: begin
        if (tx_cnt == '0) begin
          tx_cnt_nxt = CNT_BIT;
          if (tx_bit == BIT_LAST) begin
            tx_nxt       = 1'b1;
            tx_state_nxt = TX_STOP;
          end else begin
            tx_nxt       = tx_shift[0];
            tx_shift_nxt = tx_shift >> 1;
            tx_bit_nxt   = tx_bit + BIT_ONE;
          end
        end else begin
          tx_cnt_nxt = tx_cnt - CNT_ONE;
        end
      end
      TX_STOP: begin
        if (tx_cnt == '0) begin
          tx_nxt       = 1'b1;
          tready_nxt   = 1'b1;
          tx_state_nxt = TX_IDLE;
        end else begin
          tx_cnt_nxt = tx_cnt - CNT_ONE;
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  // ----------------------------------------------------------------- receive
  logic                  rx_meta, rx_sync, rx_prev;
  rx_state_t             rx_state, rx_state_nxt;
  logic [CNT_W-1:0]      rx_cnt, rx_cnt_nxt;
  logic [BIT_W-1:0]      rx_bit, rx_bit_nxt;
  logic [DATA_WIDTH-1:0] rx_shift, rx_shift_nxt;
  logic                  rx_ferr, rx_ferr_nxt;
  logic                  byte_done;
  logic [DATA_WIDTH-1:0] m_tdata_nxt;
  logic                  m_tvalid_nxt;

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      rx_meta       <= 1'b1;
      rx_sync       <= 1'b1;
      rx_prev       <= 1'b1;
      rx_state      <= RX_IDLE;
      rx_cnt        <= '0;
      rx_bit        <= '0;
      rx_shift      <= '0;
      rx_ferr       <= 1'b0;
      m_data_tdata  <= '0;
      m_data_tvalid <= 1'b0;
    end else begin
      rx_meta       <= rx;
      rx_sync       <= rx_meta;
      rx_prev       <= rx_sync;
      rx_state      <= rx_state_nxt;
      rx_cnt        <= rx_cnt_nxt;
      rx_bit        <= rx_bit_nxt;
      rx_shift      <= rx_shift_nxt;
      rx_ferr       <= rx_ferr_nxt;
      m_data_tdata  <= m_tdata_nxt;
      m_data_tvalid <= m_tvalid_nxt;
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt;
    rx_bit_nxt   = rx_bit;
    rx_shift_nxt = rx_shift;
    rx_ferr_nxt  = rx_ferr;
    byte_done    = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_sync) begin
          rx_cnt_nxt   = CNT_HALF;
          rx_state_nxt = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt == '0) begin
          if (rx_sync) begin
            rx_state_nxt = RX_IDLE;
          end else begin
            rx_cnt_nxt   = CNT_BIT;
            rx_bit_nxt   = '0;
            rx_state_nxt = RX_DATA;
          end
        end else begin
          rx_cnt_nxt = rx_cnt - CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt == '0) begin
          rx_cnt_nxt   = CNT_BIT;
          rx_shift_nxt = {rx_sync, rx_shift[DATA_WIDTH-1:1]};
          rx_bit_nxt   = rx_bit + BIT_ONE;
          if (rx_bit == BIT_LAST) rx_state_nxt = RX_STOP;
        end else begin
          rx_cnt_nxt = rx_cnt - CNT_ONE;
        end
      end
      RX_STOP: begin
        // a low stop bit parks here until the line is released
        if (rx_ferr) begin
          if (rx_sync) begin
            rx_ferr_nxt  = 1'b0;
            rx_state_nxt = RX_IDLE;
          end
        end else if (rx_cnt == '0) begin
          if (rx_sync) begin
            byte_done    = 1'b1;
            rx_state_nxt = RX_IDLE;
          end else begin
            rx_ferr_nxt = 1'b1;
          end
        end else begin
          rx_cnt_nxt = rx_cnt - CNT_ONE;
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  // a freshly completed byte wins over a downstream handshake on the same edge
  always_comb begin
    m_tdata_nxt  = m_data_tdata;
    m_tvalid_nxt = m_data_tvalid && !m_data_tready;
    if (byte_done) begin
      m_tdata_nxt  = rx_shift;
      m_tvalid_nxt = 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_axis.sv
// Directed bench for uart_axis with CLKS_PER_BIT=4: reset, tx framing,
// loopback ordering, overrun, glitch/framing rejection and async reset mid-frame.
module tb_uart_axis;

  localparam int CPB = 4;

  logic [7:0] s_data_tdata;
  logic       s_data_tvalid;
  logic       s_data_tready;
  logic [7:0] m_data_tdata;
  logic       m_data_tvalid;
  logic       m_data_tready;
  logic       tx;
  logic       rx;
  logic       aclk;
  logic       arstn;

  logic       loop_en;
  logic       rx_drv;

  int n_checks = 0;
  int n_pass   = 0;

  assign rx = loop_en ? tx : rx_drv;

  uart_axis #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
    .s_data_tdata (s_data_tdata),
    .s_data_tvalid(s_data_tvalid),
    .s_data_tready(s_data_tready),
    .m_data_tdata (m_data_tdata),
    .m_data_tvalid(m_data_tvalid),
    .m_data_tready(m_data_tready),
    .tx           (tx),
    .rx           (rx),
    .aclk         (aclk),
    .arstn        (arstn)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // one handshake, then 40 samples of tx (first sample in the MSB)
  task automatic tx_send(input logic [7:0] b, output logic [39:0] pat, output int low_cnt);
    pat = '0;
    low_cnt = 0;
    s_data_tdata  = b;
    s_data_tvalid = 1'b1;
    tick();
    s_data_tvalid = 1'b0;
    s_data_tdata  = ~b;
    for (int j = 0; j < 40; j++) begin
      pat[39-j] = tx;
      if (!s_data_tready) low_cnt++;
      tick();
    end
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx_drv = frame[k];
      repeat (CPB) tick();
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    logic [39:0] pat;
    int          low_cnt;
    logic [7:0]  exp_b;
    int          n_rx;
    logic        prev_rdy;

    s_data_tdata  = 8'h00;
    s_data_tvalid = 1'b0;
    m_data_tready = 1'b0;
    loop_en       = 1'b0;
    rx_drv        = 1'b1;
    arstn         = 1'b1;

    // reset hold 50 ns
    #1 arstn = 1'b0;
    #24;
    check("rst_tx", tx, 1'b1);
    check("rst_tready", s_data_tready, 1'b0);
    check("rst_tvalid", m_data_tvalid, 1'b0);
    check("rst_tdata", m_data_tdata, 8'h00);
    #26 arstn = 1'b1;
    #1;
    check("tready_before_edge", s_data_tready, 1'b0);
    @(posedge aclk);
    #1;
    check("tready_after_release", s_data_tready, 1'b1);

    // tx framing of 0x11
    tx_send(8'h11, pat, low_cnt);
    check("tx_pattern_11", pat, 40'h0F000F000F);
    check("tready_low_cycles", low_cnt, 40);
    check("tready_back", s_data_tready, 1'b1);
    check("tx_idle_after", tx, 1'b1);

    // loopback: held tvalid, data bumped after each handshake
    s_data_tdata  = 8'h11;
    exp_b         = 8'h11;
    n_rx          = 0;
    m_data_tready = 1'b1;
    loop_en       = 1'b1;
    prev_rdy      = s_data_tready;
    s_data_tvalid = 1'b1;
    for (int c = 0; c < 600 && n_rx < 5; c++) begin
      tick();
      if (prev_rdy && !s_data_tready) s_data_tdata = s_data_tdata + 8'h01;
      prev_rdy = s_data_tready;
      if (m_data_tvalid) begin
        check("loop_byte", m_data_tdata, exp_b);
        exp_b = exp_b + 8'h01;
        n_rx++;
      end
    end
    s_data_tvalid = 1'b0;
    check("loop_count", n_rx, 5);
    repeat (100) tick();
    loop_en       = 1'b0;
    m_data_tready = 1'b0;
    tick();
    check("loop_drained", m_data_tvalid, 1'b0);

    // hold with tready low, then overrun
    rx_send(8'hA5, 1'b1);
    repeat (3) tick();
    check("a5_valid", m_data_tvalid, 1'b1);
    check("a5_data", m_data_tdata, 8'hA5);
    repeat (10) tick();
    check("a5_held_valid", m_data_tvalid, 1'b1);
    check("a5_held_data", m_data_tdata, 8'hA5);
    rx_send(8'h3C, 1'b1);
    repeat (3) tick();
    check("overrun_valid", m_data_tvalid, 1'b1);
    check("overrun_data", m_data_tdata, 8'h3C);
    m_data_tready = 1'b1;
    tick();
    check("valid_cleared", m_data_tvalid, 1'b0);
    m_data_tready = 1'b0;

    // glitch of CPB/2-1 cycles, then framing error, then a good frame
    rx_drv = 1'b0;
    repeat (CPB/2 - 1) tick();
    rx_drv = 1'b1;
    repeat (20) tick();
    check("glitch_no_output", m_data_tvalid, 1'b0);
    rx_send(8'h5A, 1'b0);
    repeat (20) tick();
    check("ferr_no_output", m_data_tvalid, 1'b0);
    rx_send(8'hC3, 1'b1);
    repeat (3) tick();
    check("after_ferr_valid", m_data_tvalid, 1'b1);
    check("after_ferr_data", m_data_tdata, 8'hC3);
    m_data_tready = 1'b1;
    tick();
    m_data_tready = 1'b0;

    // async reset in the middle of a 0x00 frame
    s_data_tdata  = 8'h00;
    s_data_tvalid = 1'b1;
    tick();
    s_data_tvalid = 1'b0;
    repeat (10) tick();
    check("midframe_tx_low", tx, 1'b0);
    #2 arstn = 1'b0;
    #1;
    check("async_rst_tx", tx, 1'b1);
    check("async_rst_tready", s_data_tready, 1'b0);
    tick();
    tick();
    arstn = 1'b1;
    tick();
    check("tready_after_rst2", s_data_tready, 1'b1);
    tx_send(8'h96, pat, low_cnt);
    check("tx_pattern_96", pat, 40'h00FF0F00FF);
    check("tready_low_cycles_96", low_cnt, 40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
